// File: rtl/distance_newton_ctrl.sv
// distance_newton_ctrl: floor(sqrt(dx^2+dy^2)) for two unsigned 32-bit points,
// computed by integer Newton iteration over one shared restoring divider.
//
// Handshake: a request is taken when start=1 and the engine is idle at a rising
// edge. busy is high from the cycle after acceptance through the DONE cycle.
// res_valid pulses for exactly one cycle, and res/iters/converged are valid then.
// res/iters/converged are registered and keep their values while idle.
// A start seen while busy is dropped, not queued.
module distance_newton_ctrl #(
   parameter int MAX_ITER = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] x1,
   input  logic [31:0] y1,
   input  logic [31:0] x2,
   input  logic [31:0] y2,
   output logic        busy,
   output logic        res_valid,
   output logic [31:0] res,
   output logic [7:0]  iters,
   output logic        converged
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_DIV  = 3'd2,
      S_UPD  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [7:0] MAX_ITER_C = 8'(MAX_ITER);

   state_t      state;
   state_t      state_nxt;

   logic [31:0] ax, ay, bx, by;  // latched operands
   logic [31:0] sq;              // dividend, reused on every iteration
   logic [31:0] cur;             // current Newton estimate (never 0 in DIV)
   logic [31:0] dvd;             // dividend shift register
   logic [31:0] rem;             // partial remainder, always < cur
   logic [31:0] q;               // quotient being assembled MSB first
   logic [4:0]  bit_cnt;         // divider step counter 31..0
   logic [7:0]  iter_cnt;        // completed non-converging updates

   logic [31:0] dx, dy, sq_c, cur_init, diff, nxt;
   logic [32:0] manh, trial;
   logic        trial_ge;
   logic [7:0]  cnt_inc;

   // Datapath arithmetic shared by the PREP, DIV and UPD states.
   always_comb begin
      dx       = (ax >= bx) ? (ax - bx) : (bx - ax);
      dy       = (ay >= by) ? (ay - by) : (by - ay);
      sq_c     = dx * dx + dy * dy;
      manh     = {1'b0, dx} + {1'b0, dy};
      cur_init = (manh > 33'h0_0001_0000) ? 32'h0001_0000 : manh[31:0];
      trial    = {rem, dvd[31]};
      trial_ge = (trial >= {1'b0, cur});
      // Only used when trial >= cur, so the result is below cur and fits in 32 bits.
      diff     = trial[31:0] - cur;
      // floor((cur+q)/2) without a 33-bit sum: halve each term, add the carried LSB pair.
      nxt      = {1'b0, cur[31:1]} + {1'b0, q[31:1]} + {31'd0, cur[0] & q[0]};
      cnt_inc  = iter_cnt + 8'd1;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = S_PREP;
         S_PREP: state_nxt = (sq_c == 32'd0) ? S_DONE : S_DIV;
         S_DIV:  if (bit_cnt == 5'd0) state_nxt = S_UPD;
         S_UPD: begin
            if (nxt >= cur)                 state_nxt = S_DONE;
            else if (cnt_inc == MAX_ITER_C) state_nxt = S_DONE;
            else                            state_nxt = S_DIV;
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand latch, divider, Newton update and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ax <= '0; ay <= '0; bx <= '0; by <= '0;
         sq <= '0; cur <= '0; dvd <= '0; rem <= '0; q <= '0;
         bit_cnt <= '0; iter_cnt <= '0;
         res <= '0; iters <= '0; converged <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  ax <= x1; ay <= y1; bx <= x2; by <= y2;
               end
            end
            S_PREP: begin
               sq       <= sq_c;
               cur      <= cur_init;
               iter_cnt <= '0;
               dvd      <= sq_c;
               rem      <= '0;
               q        <= '0;
               bit_cnt  <= 5'd31;
               if (sq_c == 32'd0) begin
                  res       <= '0;
                  iters     <= '0;
                  converged <= 1'b1;
               end
            end
            S_DIV: begin
               rem     <= trial_ge ? diff : trial[31:0];
               q       <= {q[30:0], trial_ge};
               dvd     <= {dvd[30:0], 1'b0};
               bit_cnt <= bit_cnt - 5'd1;
            end
            S_UPD: begin
               if (nxt >= cur) begin
                  res       <= cur;
                  iters     <= cnt_inc;
                  converged <= 1'b1;
               end else begin
                  cur      <= nxt;
                  iter_cnt <= cnt_inc;
                  if (cnt_inc == MAX_ITER_C) begin
                     res       <= nxt;
                     iters     <= cnt_inc;
                     converged <= 1'b0;
                  end else begin
                     dvd     <= sq;
                     rem     <= '0;
                     q       <= '0;
                     bit_cnt <= 5'd31;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Handshake outputs decode straight from the state register.
   assign busy      = (state != S_IDLE);
   assign res_valid = (state == S_DONE);

endmodule

// File: doc/distance_newton_ctrl.md
Name: distance_newton_ctrl

Overview:
- Multi-cycle distance engine. Computes floor(sqrt(dx^2+dy^2)) for two 32-bit points using integer Newton iteration.
- Uses one shared sequential restoring divider (1 quotient bit/cycle) instead of a cascade of combinational dividers.
- Sits between the point-generation logic and downstream consumers that can tolerate tens of cycles of latency.
- Start/busy handshake in; one-cycle result strobe out.

Parameters:
- MAX_ITER, 16, maximum Newton iterations before forced exit; legal range 1..255.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; accepted only when busy=0
- x1  input  32  point A x, unsigned
- y1  input  32  point A y, unsigned
- x2  input  32  point B x, unsigned
- y2  input  32  point B y, unsigned
- busy  output  1  high from the cycle after acceptance through the DONE cycle
- res_valid  output  1  one-cycle strobe, res/iters/converged valid
- res  output  32  distance result; held until next acceptance
- iters  output  8  Newton iterations performed
- converged  output  1  1 = exited on convergence, 0 = exited on MAX_ITER

Behaviour:
- Reset: clk and synchronous active-low reset rst_n are already decided. While rst_n=0 at a rising edge: state=IDLE, busy=0, res_valid=0, res=0, iters=0, converged=0, and all internal registers cleared. Reset mid-operation aborts the computation with no res_valid.
- Acceptance: start=1 && state==IDLE at an edge latches x1..y2. A start while busy is ignored, not queued. Inputs need only be stable in the acceptance cycle.
- States: IDLE -> PREP -> DIV -> UPD -> (DIV | DONE) -> IDLE. PREP may go directly to DONE.
- PREP (1 cycle):
  - dx=|x1-x2|, dy=|y1-y2| (compare-then-subtract, unsigned).
  - sq=(dx*dx+dy*dy) mod 2^32. Truncation matches the team's combinational distance datapath.
  - manh=dx+dy computed in 33 bits, then cur=min(manh, 32'h0001_0000). cur >= floor(sqrt(sq)) always.
  - If sq==0: res=0, iters=0, converged=1, go to DONE. Otherwise clear the iteration counter and go to DIV.
- DIV (exactly 32 cycles): restoring division q=sq/cur, MSB first. Bit counter 31..0. cur is never 0 here.
- UPD (1 cycle):
  - next=(cur+q)>>1, with the sum in 33 bits; next fits in 32 bits.
  - If next>=cur: res=cur, converged=1, go to DONE.
  - Else: cur<=next, iteration counter +1. If the counter reaches MAX_ITER: res=next, converged=0, go to DONE. Otherwise go to DIV.
  - iters = number of UPD cycles executed.
- DONE (1 cycle): res_valid=1, busy=1. Next state IDLE; busy=0 the cycle after.
- Latency: count the first cycle after the acceptance edge as cycle 1. res_valid is high in cycle 2+33*iters. For the sq==0 path, res_valid is high in cycle 2.
- Throughput: a new start may be accepted in the first IDLE cycle after DONE.
- res, iters and converged are registered. They keep their values after res_valid falls and change only at the next PREP/UPD/DONE.
- No combinational path from any input to any output.

Test Plan:
- (x1,y1,x2,y2)=(0,0,3,4) -> sq=25, init 7, 7->5->5; res=5, iters=2, converged=1; res_valid in cycle 68 for exactly 1 cycle.
- (10,20,7,16) -> reversed-order abs diffs 3,4; res=5, iters=2. (0,0,1,1) -> res=1, iters=2.
- (5,5,5,5) -> sq=0 fast path; res=0, iters=0, converged=1, res_valid in cycle 2. (0,0,65536,0) -> sq truncates to 0; res=0 in cycle 2.
- MAX_ITER=1 with (0,0,3,4) -> res=5, iters=1, converged=0, res_valid in cycle 35.
- start held high continuously with changing inputs -> only the first vector is used; busy=1 throughout; the next acceptance occurs on the first IDLE cycle after DONE.
- rst_n=0 for 1 cycle during DIV of (0,0,3,4) -> next cycle: busy=0, res=0, no res_valid ever. A following start with (0,0,6,8) -> res=10, correct.
